// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the byte-enable helper used by the lane aligner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr_lo;
      F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for RV32 loads/stores: byte enables, replicated
// store data, sign/zero-extended load data and the misalignment flag.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be_o       = byte_en(funct3_i, addr_lo_i);
    wdata_o    = 32'd0;
    rdata_o    = 32'd0;
    misalign_o = 1'b0;
    case (addr_lo_i)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
    rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    // Store data is replicated into every lane; the byte enables pick the live ones.
    case (funct3_i)
      F3_B: begin
        rdata_o = {{24{rbyte[7]}}, rbyte};
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_BU: begin
        rdata_o = {24'd0, rbyte};
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        rdata_o    = {{16{rhalf[15]}}, rhalf};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      F3_HU: begin
        rdata_o    = {16'd0, rhalf};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      F3_W: begin
        rdata_o    = rword_i;
        wdata_o    = wdata_i;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: accepts a load/store, waits LATENCY
// cycles, commits to the word array and holds the response until taken.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [2:0]  f3_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept, commit, mem_we;
  logic [31:0]      cur_addr, cur_wdata, rword;
  logic             cur_write;
  logic [2:0]       cur_f3;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]       be;
  logic [31:0]      wlane, rext;
  logic             misalign, illegal, oor, fault;

  // With LATENCY==1 the commit happens on the accept edge itself, so the live
  // request fields are used; otherwise the latched copy.
  assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign cur_write = (state_q == IDLE) ? req_write  : write_q;
  assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign cur_idx   = cur_addr[IDX_W+1:2];
  assign rword     = mem_q[cur_idx];

  mem_lane_align u_align (
    .funct3_i   (cur_f3),
    .addr_lo_i  (cur_addr[1:0]),
    .rword_i    (rword),
    .wdata_i    (cur_wdata),
    .be_o       (be),
    .wdata_o    (wlane),
    .rdata_o    (rext),
    .misalign_o (misalign)
  );

  always_comb begin
    illegal = 1'b1;
    if (cur_write) begin
      illegal = (cur_f3 > F3_W);
    end else begin
      case (cur_f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal = 1'b0;
        default:                         illegal = 1'b1;
      endcase
    end
  end

  assign oor    = ({1'b0, cur_addr} >= ADDR_LIMIT);
  assign fault  = illegal | misalign | oor;
  assign accept = req_valid & req_ready;
  assign mem_we = commit & ~fault & cur_write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    commit      = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            cnt_d = CNT_LOAD;
            if (LATENCY == 1) begin
              state_d = RESP;
              commit  = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
        RESP: begin
          rsp_valid = 1'b1;
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (commit) begin
      rsp_fault_d = fault;
      rsp_rdata_d = (fault || cur_write) ? 32'd0 : rext;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      write_q <= req_write;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[cur_idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 2, 3, 1) with directed and random loads and
// stores, checking latency, data, faults and handshake against a byte model.
module tb_dmem_responder;

  localparam int NU    = 3;
  localparam int DEPTH = 64;

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 3 : 1);
  endfunction

  logic              clk = 1'b0;
  logic [NU-1:0]     rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_fault;
  logic [31:0]       req_addr  [NU];
  logic [31:0]       req_wdata [NU];
  logic [2:0]        req_funct3[NU];
  logic [31:0]       rsp_rdata [NU];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int last_acc[NU];
  logic [31:0] got_rdata;
  logic        got_fault;

  logic [7:0] ref_mem [NU][DEPTH*4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < NU; gi++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(lat_of(gi))) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_addr   (req_addr[gi]),
      .req_write  (req_write[gi]),
      .req_wdata  (req_wdata[gi]),
      .req_funct3 (req_funct3[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_fault  (rsp_fault[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, fault from size/alignment/range, bytes in an array.
  function automatic void model(input int u, input bit wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output bit flt);
    int size;
    bit sgn;
    size = 0;
    sgn  = 1'b0;
    rd   = 32'd0;
    if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    flt = (size == 0) || (addr >= 32'(DEPTH * 4)) || ((addr % 32'(size)) != 0);
    if (!flt) begin
      if (wr) begin
        for (int i = 0; i < size; i++) ref_mem[u][addr + 32'(i)] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[u][addr + 32'(i)];
        if (sgn && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
      end
    end
  endfunction

  // One full transaction; starts and ends just after a falling edge.
  task automatic xact(input int u, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold, input bit spacing);
    logic [31:0] exp_rd;
    bit          exp_flt;
    int          n, acc_cyc;
    n = 0;
    while (req_ready[u] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(req_ready[u]), 32'd1);
    req_valid[u]  = 1'b1;
    req_write[u]  = wr;
    req_funct3[u] = f3;
    req_addr[u]   = addr;
    req_wdata[u]  = wd;
    rsp_ready[u]  = (hold == 0);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    req_valid[u]  = 1'b0;
    req_addr[u]   = $urandom;
    req_wdata[u]  = $urandom;
    req_write[u]  = 1'($urandom);
    req_funct3[u] = 3'($urandom);
    model(u, wr, f3, addr, wd, exp_rd, exp_flt);
    if (spacing) chk("accept_spacing", 32'(acc_cyc - last_acc[u]), 32'(lat_of(u) + 1));
    last_acc[u] = acc_cyc;
    @(negedge clk);
    n = 1;
    while (rsp_valid[u] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat_of(u)));
    got_rdata = rsp_rdata[u];
    got_fault = rsp_fault[u];
    chk("rdata", got_rdata, exp_rd);
    chk("fault", 32'(got_fault), 32'(exp_flt));
    chk("req_ready_busy", 32'(req_ready[u]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid[u]), 32'd1);
      chk("hold_rdata", rsp_rdata[u], exp_rd);
      chk("hold_fault", 32'(rsp_fault[u]), 32'(exp_flt));
      chk("hold_req_ready", 32'(req_ready[u]), 32'd0);
    end
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    chk("valid_drop", 32'(rsp_valid[u]), 32'd0);
    chk("req_ready_back", 32'(req_ready[u]), 32'd1);
    $display("txn u=%0d lat=%0d wr=%0d f3=%0d addr=%h wdata=%h rdata=%h fault=%0d hold=%0d",
             u, n, wr, f3, addr, wd, got_rdata, got_fault, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_word, addr;
    int          u, pick;
    rst       = '1;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    for (int i = 0; i < NU; i++) begin
      req_addr[i]   = 32'd0;
      req_wdata[i]  = 32'd0;
      req_funct3[i] = 3'd0;
      last_acc[i]   = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      chk("rst_rsp_fault", 32'(rsp_fault[i]), 32'd0);
    end
    rst = '0;
    @(negedge clk);
    for (int i = 0; i < NU; i++) chk("post_rst_req_ready", 32'(req_ready[i]), 32'd1);

    for (int i = 0; i < NU; i++)
      for (int w = 0; w < DEPTH; w++) xact(i, 1'b1, 3'd2, 32'(w * 4), $urandom, 0, 1'b0);

    // Directed byte/halfword/word sequence on the LATENCY=2 unit.
    xact(0, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 1'b0);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    chk("lw_deadbeef", got_rdata, 32'hDEAD_BEEF);
    xact(0, 1'b1, 3'd0, 32'h11, 32'h1234_567F, 0, 1'b0);
    xact(0, 1'b0, 3'd0, 32'h11, 32'h0, 0, 1'b0);
    chk("lb_7f", got_rdata, 32'h0000_007F);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    chk("lw_merged", got_rdata, 32'hDEAD_7FEF);
    xact(0, 1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0);
    chk("lbu_de", got_rdata, 32'h0000_00DE);
    xact(0, 1'b0, 3'd1, 32'h12, 32'h0, 0, 1'b0);
    chk("lh_sext", got_rdata, 32'hFFFF_DEAD);

    // Faults: misaligned, out of range, illegal funct3; array must be untouched.
    xact(0, 1'b0, 3'd1, 32'h13, 32'h0, 0, 1'b0);
    chk("lh_misalign_fault", 32'(got_fault), 32'd1);
    xact(0, 1'b0, 3'd2, 32'h12, 32'h0, 0, 1'b0);
    xact(0, 1'b1, 3'd2, 32'(DEPTH * 4), 32'h5555_AAAA, 0, 1'b0);
    chk("sw_oor_fault", 32'(got_fault), 32'd1);
    xact(0, 1'b1, 3'd4, 32'h10, 32'h0BAD_0BAD, 0, 1'b0);
    xact(0, 1'b0, 3'd3, 32'h10, 32'h0, 0, 1'b0);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0);
    chk("lw_after_faults", got_rdata, 32'hDEAD_7FEF);

    // Back-pressure for five cycles, then an immediate follow-on request.
    xact(0, 1'b0, 3'd0, 32'h10, 32'h0, 5, 1'b0);
    xact(0, 1'b0, 3'd5, 32'h12, 32'h0, 0, 1'b0);

    // Back-to-back on the LATENCY=1 unit with rsp_ready held high.
    xact(2, 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, 0, 1'b0);
    for (int k = 0; k < 8; k++)
      xact(2, 1'($urandom), 3'($urandom_range(0, 2)), 32'(32'h40 + 32'(k)), $urandom, 0, 1'b1);

    // Reset while a store is waiting on the LATENCY=3 unit.
    old_word = {ref_mem[1][35], ref_mem[1][34], ref_mem[1][33], ref_mem[1][32]};
    req_valid[1]  = 1'b1;
    req_write[1]  = 1'b1;
    req_funct3[1] = 3'd2;
    req_addr[1]   = 32'h20;
    req_wdata[1]  = ~old_word;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    rst[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      chk("after_rst_req_ready", 32'(req_ready[1]), 32'd1);
    end
    xact(1, 1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0);
    chk("aborted_store_absent", got_rdata, old_word);

    // Random mix across all units.
    for (int k = 0; k < 300; k++) begin
      u    = $urandom_range(0, NU - 1);
      pick = $urandom_range(0, 15);
      if (pick == 0)      addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
      else if (pick == 1) addr = $urandom;
      else                addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      xact(u, 1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
